// File: rtl/cw_keyer_tx.sv
`default_nettype none
// ============================================================================
// cw_keyer_tx : Morse keyer/transmitter timing symbols in dot units and
//               producing key envelope, keyed audio tone and keyed RF carrier.
// Revision    : 1.0
// ============================================================================
module cw_keyer_tx #(
    parameter int DOT_DIV   = 8192,
    parameter int TONE_HALF = 8192,
    parameter int RF_HALF   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    output logic       sym_ready,
    input  logic       mcw,
    output logic       busy,
    output logic       out_lf,
    output logic       out_audio,
    output logic       out_rf
);

    localparam int UW = $clog2(DOT_DIV);
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int RW = (RF_HALF > 1) ? $clog2(RF_HALF) : 1;

    localparam logic [UW-1:0] C_UNIT_LAST = UW'(DOT_DIV - 1);
    localparam logic [TW-1:0] C_TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [RW-1:0] C_RF_LAST   = RW'(RF_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [UW-1:0] unit_cnt_q, unit_cnt_d;
    logic [2:0]    units_left_q, units_left_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic [RW-1:0] rf_cnt_q, rf_cnt_d;
    logic          tone_sq_q, tone_sq_d;
    logic          rf_sq_q, rf_sq_d;

    logic w_unit_end;
    logic w_last_unit;
    logic w_accept;
    logic w_load;
    logic w_tone_wrap;
    logic w_rf_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            unit_cnt_q   <= '0;
            units_left_q <= '0;
            tone_cnt_q   <= '0;
            rf_cnt_q     <= '0;
            tone_sq_q    <= 1'b0;
            rf_sq_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_cnt_q   <= unit_cnt_d;
            units_left_q <= units_left_d;
            tone_cnt_q   <= tone_cnt_d;
            rf_cnt_q     <= rf_cnt_d;
            tone_sq_q    <= tone_sq_d;
            rf_sq_q      <= rf_sq_d;
        end
    end

    // Free-running square-wave dividers, unrelated to symbol timing
    always_comb begin
        w_tone_wrap = (tone_cnt_q == C_TONE_LAST);
        w_rf_wrap   = (rf_cnt_q == C_RF_LAST);
        tone_cnt_d  = w_tone_wrap ? '0 : tone_cnt_q + 1'b1;
        rf_cnt_d    = w_rf_wrap ? '0 : rf_cnt_q + 1'b1;
        tone_sq_d   = tone_sq_q ^ w_tone_wrap;
        rf_sq_d     = rf_sq_q ^ w_rf_wrap;
    end

    assign w_unit_end  = (unit_cnt_q == C_UNIT_LAST);
    assign w_last_unit = w_unit_end && (units_left_q == 3'd1);
    assign sym_ready   = (state_q == ST_IDLE) || ((state_q == ST_SPACE) && w_last_unit);
    assign w_accept    = sym_valid && sym_ready;

    always_comb begin
        state_d      = state_q;
        unit_cnt_d   = w_unit_end ? '0 : unit_cnt_q + 1'b1;
        units_left_d = w_unit_end ? units_left_q - 3'd1 : units_left_q;
        w_load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                unit_cnt_d   = '0;
                units_left_d = '0;
                w_load       = w_accept;
            end
            ST_MARK: begin
                if (w_last_unit) begin
                    state_d      = ST_SPACE;
                    unit_cnt_d   = '0;
                    units_left_d = 3'd1;
                end
            end
            ST_SPACE: begin
                if (w_last_unit) begin
                    state_d      = ST_IDLE;
                    unit_cnt_d   = '0;
                    units_left_d = '0;
                    w_load       = w_accept;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                unit_cnt_d   = '0;
                units_left_d = '0;
            end
        endcase
        // A symbol accepted at the end of a space tiles straight on
        if (w_load) begin
            unit_cnt_d = '0;
            case (sym_code)
                2'd0: begin state_d = ST_MARK;  units_left_d = 3'd1; end
                2'd1: begin state_d = ST_MARK;  units_left_d = 3'd3; end
                2'd2: begin state_d = ST_SPACE; units_left_d = 3'd2; end
                default: begin state_d = ST_SPACE; units_left_d = 3'd6; end
            endcase
        end
    end

    assign out_lf    = (state_q == ST_MARK);
    assign busy      = (state_q != ST_IDLE);
    assign out_audio = out_lf & tone_sq_q;
    assign out_rf    = out_lf & rf_sq_q & (mcw ? tone_sq_q : 1'b1);

endmodule
`default_nettype wire

// File: tb/tb_cw_keyer_tx.sv
`default_nettype none
// ============================================================================
// tb_cw_keyer_tx : scoreboard bench for cw_keyer_tx (DOT_DIV=4, TONE_HALF=3,
//                  RF_HALF=1).
// Revision       : 1.0
// ============================================================================
module tb_cw_keyer_tx;

    localparam int DOT = 4;
    localparam int TH  = 3;
    localparam int RH  = 1;

    logic       clk;
    logic       rst;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic       sym_ready;
    logic       mcw;
    logic       busy;
    logic       out_lf;
    logic       out_audio;
    logic       out_rf;

    cw_keyer_tx #(
        .DOT_DIV  (DOT),
        .TONE_HALF(TH),
        .RF_HALF  (RH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sym_valid(sym_valid),
        .sym_code (sym_code),
        .sym_ready(sym_ready),
        .mcw      (mcw),
        .busy     (busy),
        .out_lf   (out_lf),
        .out_audio(out_audio),
        .out_rf   (out_rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic lf;
        logic busy;
        logic ready;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] pend[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         n_edge;

    // Clock edges since reset release; square waves follow from this count
    always @(posedge clk or posedge rst) begin
        if (rst) n_edge <= 0;
        else     n_edge <= n_edge + 1;
    end

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    task automatic push_timeline(input logic [1:0] code);
        int   mark_u;
        int   space_u;
        exp_t e;
        mark_u  = (code == 2'd0) ? 1 : (code == 2'd1) ? 3 : 0;
        space_u = (code == 2'd2) ? 2 : (code == 2'd3) ? 6 : 1;
        for (int i = 0; i < mark_u * DOT; i++) begin
            e.lf = 1'b1; e.busy = 1'b1; e.ready = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < space_u * DOT; i++) begin
            e.lf = 1'b0; e.busy = 1'b1; e.ready = (i == space_u * DOT - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        logic tone;
        logic rfw;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.lf = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
        end
        tone = ((n_edge / TH) % 2) == 1;
        rfw  = ((n_edge / RH) % 2) == 1;
        check("lf",    int'(out_lf),    int'(e.lf));
        check("busy",  int'(busy),      int'(e.busy));
        check("ready", int'(sym_ready), int'(e.ready));
        check("audio", int'(out_audio), int'(e.lf & tone));
        check("rf",    int'(out_rf),    int'(e.lf & rfw & (mcw ? tone : 1'b1)));
        sym_valid = (pend.size() > 0);
        sym_code  = (pend.size() > 0) ? pend[0] : 2'd0;
        if (sym_valid && e.ready) push_timeline(pend.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_code  = 2'd0;
        mcw       = 1'b0;
        run(2);
        rst = 1'b0;

        // idle after reset
        run(20);

        // single dot
        pend.push_back(2'd0);
        run(12);

        // dash then dot with valid held
        pend.push_back(2'd1);
        pend.push_back(2'd0);
        run(25);

        // dot, char gap, dot; then dot, word gap, dot
        pend.push_back(2'd0); pend.push_back(2'd2); pend.push_back(2'd0);
        run(30);
        pend.push_back(2'd0); pend.push_back(2'd3); pend.push_back(2'd0);
        run(45);

        // gap from idle never keys
        pend.push_back(2'd2);
        run(12);

        // mcw switched on midway through a dash
        mcw = 1'b0;
        pend.push_back(2'd1);
        run(6);
        mcw = 1'b1;
        run(14);
        mcw = 1'b0;

        // reset pulsed during cycle 6 of a dash
        pend.push_back(2'd1);
        run(7);
        #2;
        rst = 1'b1;
        #1;
        check("rst_lf",    int'(out_lf),    0);
        check("rst_rf",    int'(out_rf),    0);
        check("rst_audio", int'(out_audio), 0);
        check("rst_busy",  int'(busy),      0);
        check("rst_ready", int'(sym_ready), 1);
        exp_q.delete();
        pend.delete();
        sym_valid = 1'b0;
        run(2);
        rst = 1'b0;
        pend.push_back(2'd0);
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cw_keyer_tx.md
Name: cw_keyer_tx

Overview:
Parametrised Morse keyer/transmitter, the successor to the fixed-pattern CW beacon. It takes a stream of Morse symbols over a valid/ready handshake and times each mark and space in dot units. It produces the key envelope (LF), a keyed audio tone, and a keyed RF carrier. The RF carrier runs in CW (carrier only) or MCW (carrier AND tone) mode. It sits between a message source (ROM sequencer or host) and the CPLD output pins.

Parameters:
DOT_DIV, 8192, clocks per Morse dot unit (>=2)
TONE_HALF, 8192, clocks per half-period of audio tone square wave (>=1)
RF_HALF, 16, clocks per half-period of RF square wave (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sym_valid  in  1  symbol present on sym_code
sym_code  in  2  0=dot, 1=dash, 2=char gap, 3=word gap
sym_ready  out  1  keyer accepts symbol this cycle
mcw  in  1  1: RF modulated by tone; 0: plain carrier
busy  out  1  symbol in progress
out_lf  out  1  key envelope
out_audio  out  1  keyed tone
out_rf  out  1  keyed RF

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all counters 0; tone_sq=0, rf_sq=0.
  - out_lf, out_audio, out_rf, busy = 0 immediately.
  - sym_ready=1 once state is IDLE.
- Dividers:
  - Free-running from reset release, independent of symbols.
  - tone_cnt counts 0..TONE_HALF-1; at TONE_HALF-1 it wraps to 0 and tone_sq toggles.
  - rf_cnt/rf_sq behave the same with RF_HALF.
- Unit timer:
  - unit_cnt, $clog2(DOT_DIV) bits, counts 0..DOT_DIV-1.
  - Cleared on symbol accept and on every state change.
  - units_left, 3 bits, decrements at unit_cnt wrap.
- FSM states: IDLE, MARK, SPACE.
  - IDLE: on accept, code 0 -> MARK with 1 unit; code 1 -> MARK with 3 units; code 2 -> SPACE with 2 units; code 3 -> SPACE with 6 units.
  - MARK: when the last unit ends -> SPACE with 1 unit (inter-element gap).
  - SPACE: when the last unit ends -> IDLE, unless a symbol is accepted on that cycle, in which case it loads that symbol directly (no idle cycle).
- Handshake:
  - sym_ready = (state==IDLE) OR (state==SPACE AND units_left==1 AND unit_cnt==DOT_DIV-1). It is combinational.
  - Accept = sym_valid & sym_ready.
  - sym_code is sampled only at accept.
  - sym_valid held while not ready has no effect.
- Timing:
  - Dot: key high for exactly DOT_DIV cycles starting the cycle after accept, then low DOT_DIV.
  - Dash: high 3*DOT_DIV, then low DOT_DIV.
  - Back-to-back symbols tile with no extra cycles.
  - Char gap adds 2 units (3 total after an element); word gap adds 6 (7 total).
- Outputs:
  - out_lf = registered key (state==MARK).
  - busy = (state!=IDLE).
  - out_audio = out_lf & tone_sq.
  - out_rf = out_lf & rf_sq & (mcw ? tone_sq : 1).
- mcw:
  - Not latched; a change takes effect on out_rf the same cycle.
  - Does not affect timing.
- Gap codes: a gap code accepted from IDLE still produces SPACE only; key never asserts.
- Reset mid-symbol: key drops asynchronously; the symbol is discarded, not resumed.

Test Plan:
All scenarios use DOT_DIV=4, TONE_HALF=3, RF_HALF=1. Cycle 0 = accept cycle.
1. Reset, then idle 20 cycles.
   -> out_lf/out_audio/out_rf/busy = 0 throughout.
   -> sym_ready=1 throughout.
   -> tone_sq toggles every 3 cycles; rf_sq toggles every cycle.
2. Single dot, code 0 accepted at cycle 0.
   -> out_lf=1 cycles 1-4, 0 cycles 5-8.
   -> sym_ready=1 at cycle 8.
   -> busy=1 cycles 1-8, busy=0 from cycle 9.
3. Dash then dot, sym_valid held high.
   -> out_lf=1 cycles 1-12, 0 cycles 13-16.
   -> dot accepted at cycle 16; out_lf=1 cycles 17-20.
   -> sym_ready=0 in all other busy cycles.
4. Dot, char gap, dot, back-to-back.
   -> key low cycles 5-16 (12 cycles = 3 units); second dot high cycles 17-20.
   -> Repeat with word gap: key low 28 cycles (7 units).
5. Dash with mcw=0, then mcw=1 midway.
   -> out_rf = rf_sq while key is high, then rf_sq & tone_sq after mcw=1.
   -> out_audio is unchanged by mcw.
   -> out_lf/out_audio/out_rf = 0 whenever the key is low.
6. rst pulsed at cycle 6 of a dash.
   -> out_lf/out_rf = 0 in the same cycle.
   -> After release: busy=0, sym_ready=1, next dot timed exactly as in scenario 2.
